// File: rtl/pc_unit.sv
// pc_unit: program counter with RUN/HANDLER trap FSM and optional return-address stack.
// Define PC_UNIT_RAS_EN to enable the return-address stack (Call pushes, Ret pops).
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_Target,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Trap,
  input  logic            Trap_Return,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Plus4,
  output logic [XLEN-1:0] EPC,
  output logic            In_Handler,
  output logic            Double_Fault,
  output logic            RAS_Empty
);
  typedef enum logic {RUN, HANDLER} state_t;
  state_t          state, state_nx;
  logic [XLEN-1:0] pc_nx, epc_nx, ras_top;
  logic            df_nx, trap, tret, pop;
  assign PC_Plus4   = PC + XLEN'(4);
  assign trap       = Trap || (Redirect && Redirect_Target[1:0] != 2'b00);
  assign tret       = Trap_Return && state == HANDLER;
  assign In_Handler = state == HANDLER;
`ifdef PC_UNIT_RAS_EN
  localparam int           PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0]  FULL = (PW+1)'(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   tp;
  logic [PW:0]     cnt;
  logic            push;
  // Circular buffer: tp is the next write slot, so a push when full overwrites the oldest entry.
  assign push      = !trap && !tret && Redirect && Call;
  assign pop       = !trap && !tret && !Redirect && Ret && !Stall && cnt != '0;
  assign ras_top   = ras[tp - PW'(1)];
  assign RAS_Empty = cnt == '0;
  always_ff @(posedge clk)
    if (push) ras[tp] <= PC_Plus4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push) begin
      tp  <= tp + PW'(1);
      cnt <= cnt == FULL ? cnt : cnt + (PW+1)'(1);
    end else if (pop) begin
      tp  <= tp - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
`else
  logic unused_ras;
  assign unused_ras = ^{Call, Ret};
  assign ras_top    = '0;
  assign pop        = 1'b0;
  assign RAS_Empty  = 1'b1;
`endif
  always_comb begin
    pc_nx    = trap ? TRAP_VECTOR : tret ? EPC : Redirect ? Redirect_Target :
               pop ? ras_top : Stall ? PC : PC_Plus4;
    epc_nx   = trap && state == RUN ? PC : EPC;
    state_nx = trap ? HANDLER : tret ? RUN : state;
    df_nx    = Double_Fault || (trap && state == HANDLER);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      PC           <= RESET_VECTOR;
      EPC          <= '0;
      state        <= RUN;
      Double_Fault <= 1'b0;
    end else begin
      PC           <= pc_nx;
      EPC          <= epc_nx;
      state        <= state_nx;
      Double_Fault <= df_nx;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus for pc_unit, checked every cycle against a queue-based behavioural model.
module tb_pc_unit;
  localparam logic [31:0] RV = 32'h0, TV = 32'h100;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, Stall = 0, Redirect = 0, Call = 0, Ret = 0, Trap = 0, Trap_Return = 0;
  logic [31:0] Redirect_Target = 0;
  logic [31:0] PC, PC_Plus4, EPC;
  logic In_Handler, Double_Fault, RAS_Empty;
  int checks = 0, failures = 0;
  logic [31:0] m_pc = RV, m_epc = 0;
  logic m_h = 0, m_df = 0, m_trap = 0;
  logic [31:0] m_ras[$];
  always #5 clk = ~clk;
  pc_unit dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Redirect(Redirect), .Redirect_Target(Redirect_Target),
    .Call(Call), .Ret(Ret), .Trap(Trap), .Trap_Return(Trap_Return), .PC(PC), .PC_Plus4(PC_Plus4),
    .EPC(EPC), .In_Handler(In_Handler), .Double_Fault(Double_Fault), .RAS_Empty(RAS_Empty)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Model: take the highest-priority applicable request, RAS kept as a bounded queue.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_pc = RV; m_epc = 0; m_h = 0; m_df = 0;
      m_ras.delete();
    end else begin
      m_trap = Trap || (Redirect && Redirect_Target[1:0] != 0);
      if (m_trap) begin
        if (m_h) m_df = 1;
        else m_epc = m_pc;
        m_h = 1;
        m_pc = TV;
      end else if (Trap_Return && m_h) begin
        m_pc = m_epc;
        m_h = 0;
      end else if (Redirect) begin
`ifdef PC_UNIT_RAS_EN
        if (Call) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        m_pc = Redirect_Target;
      end
`ifdef PC_UNIT_RAS_EN
      else if (Ret && !Stall && m_ras.size() > 0) m_pc = m_ras.pop_back();
`endif
      else if (!Stall) m_pc = m_pc + 32'd4;
    end
  always @(negedge clk) begin
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_Plus4, m_pc + 32'd4);
    chk("epc", EPC, m_epc);
    chk("in_handler", 32'(In_Handler), 32'(m_h));
    chk("double_fault", 32'(Double_Fault), 32'(m_df));
`ifdef PC_UNIT_RAS_EN
    chk("ras_empty", 32'(RAS_Empty), 32'(m_ras.size() == 0));
`else
    chk("ras_empty", 32'(RAS_Empty), 32'd1);
`endif
  end
  task automatic cyc(input logic st, input logic rd, input logic [31:0] tg,
                     input logic cl, input logic rt, input logic tp, input logic tr);
    Stall = st; Redirect = rd; Redirect_Target = tg; Call = cl; Ret = rt; Trap = tp; Trap_Return = tr;
    @(posedge clk); #1;
    Stall = 0; Redirect = 0; Redirect_Target = 0; Call = 0; Ret = 0; Trap = 0; Trap_Return = 0;
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask
  initial begin
    #1 rst = 0;
    @(posedge clk); #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_ras_empty", 32'(RAS_Empty), 32'd1);
    rst = 1;
    idle(); chk("seq_4", PC, 32'h4);
    idle(); chk("seq_8", PC, 32'h8);
    idle(); chk("seq_c", PC, 32'hC);
    do_reset(); idle(); idle(); chk("pre_stall_pc", PC, 32'h8);
    cyc(1, 1, 32'h40, 0, 0, 0, 0); chk("redir_over_stall", PC, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0); chk("stall_hold1", PC, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0); chk("stall_hold2", PC, 32'h40);
    cyc(0, 1, 32'h10, 0, 0, 0, 0); chk("redir_10", PC, 32'h10);
    cyc(0, 1, 32'h22, 0, 0, 0, 0);
    chk("misalign_pc", PC, 32'h100); chk("misalign_epc", EPC, 32'h10);
    chk("misalign_handler", 32'(In_Handler), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("dfault", 32'(Double_Fault), 32'd1); chk("dfault_epc", EPC, 32'h10);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("tret_pc", PC, 32'h10); chk("tret_handler", 32'(In_Handler), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1); chk("tret_in_run_ignored", PC, 32'h14);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    chk("top_pc", PC, 32'hFFFF_FFFC); chk("top_plus4_wrap", PC_Plus4, 32'h0);
    idle(); chk("wrap_pc", PC, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("trap_pc", PC, 32'h100);
    Trap = 1; #2 rst = 0; #1;
    chk("async_rst_pc", PC, 32'h0); chk("async_rst_handler", 32'(In_Handler), 32'd0);
    chk("async_rst_df", 32'(Double_Fault), 32'd0);
    @(posedge clk); #1;
    Trap = 0; rst = 1;
    chk("post_rst_pc", PC, 32'h0);
    idle(); chk("post_rst_adv", PC, 32'h4);
`ifdef PC_UNIT_RAS_EN
    do_reset(); idle();
    cyc(0, 1, 32'h80, 1, 0, 0, 0); chk("call1", PC, 32'h80);
    chk("call1_nonempty", 32'(RAS_Empty), 32'd0);
    cyc(0, 1, 32'hC0, 1, 0, 0, 0); chk("call2", PC, 32'hC0);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("ret1", PC, 32'h84);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("ret2", PC, 32'h8);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("ret_empty_pc", PC, 32'hC);
    chk("ret_empty_flag", 32'(RAS_Empty), 32'd1);
    cyc(0, 1, 32'h202, 1, 0, 0, 0); chk("trap_cancels_push", 32'(RAS_Empty), 32'd1);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'(i + 2) << 8, 1, 0, 0, 0);
    chk("five_calls_pc", PC, 32'h600);
    cyc(1, 0, 0, 0, 1, 0, 0); chk("ret_stalled", PC, 32'h600);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("oret1", PC, 32'h504);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("oret2", PC, 32'h404);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("oret3", PC, 32'h304);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("oret4", PC, 32'h204);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("oret5_ignored", PC, 32'h208);
    chk("oret_empty", 32'(RAS_Empty), 32'd1);
`else
    do_reset(); idle();
    cyc(0, 1, 32'h80, 1, 0, 0, 0); chk("call_noras", PC, 32'h80);
    chk("noras_empty", 32'(RAS_Empty), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("ret_noras", PC, 32'h84);
`endif
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, trap handler entry address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Stall  input  1  hold PC and suppress sequential advance.
REQ-008 SHALL have port Redirect  input  1  branch/jump taken this cycle.
REQ-009 SHALL have port Redirect_Target  input  XLEN  branch/jump destination.
REQ-010 SHALL have port Call  input  1  qualifies Redirect as a call (push return address).
REQ-011 SHALL have port Ret  input  1  return request, target taken from RAS.
REQ-012 SHALL have port Trap  input  1  synchronous exception request.
REQ-013 SHALL have port Trap_Return  input  1  leave handler, resume at EPC.
REQ-014 SHALL have port PC  output  XLEN  current fetch address.
REQ-015 SHALL have port PC_Plus4  output  XLEN  PC+4, combinational, modulo 2^XLEN.
REQ-016 SHALL have port EPC  output  XLEN  saved exception PC.
REQ-017 SHALL have port In_Handler  output  1  high while FSM in HANDLER.
REQ-018 SHALL have port Double_Fault  output  1  sticky, set on trap while in HANDLER.
REQ-019 SHALL have port RAS_Empty  output  1  RAS holds no valid entry.

Function
REQ-020 SHALL implement FSM with states RUN and HANDLER; In_Handler = (state==HANDLER).
REQ-021 SHALL select next PC each rising edge by priority: Trap (incl. misaligned) > Trap_Return (HANDLER only) > Redirect > Ret (RAS non-empty) > Stall hold > PC_Plus4.
REQ-022 SHALL treat Redirect with Redirect_Target[1:0]!=0 as a Trap; PC never takes a misaligned value.
REQ-023 SHALL, on Trap in RUN: EPC<=PC, PC<=TRAP_VECTOR, state<=HANDLER, next cycle.
REQ-024 SHALL, on Trap in HANDLER: PC<=TRAP_VECTOR, EPC unchanged, Double_Fault<=1, state stays HANDLER.
REQ-025 SHALL, on Trap_Return in HANDLER: PC<=EPC, state<=RUN; Trap_Return in RUN ignored.
REQ-026 SHALL let Trap, Trap_Return and Redirect override Stall; Ret and sequential advance are blocked by Stall.
REQ-027 SHALL compute PC_Plus4 modulo 2^XLEN (all-ones-minus-3 wraps to 0, no flag).
REQ-028 SHALL update PC, EPC, FSM, RAS with one-cycle latency; no combinational path from inputs to PC.

Reset
REQ-029 SHALL, while rst=0, force asynchronously: PC=RESET_VECTOR, EPC=0, state=RUN, Double_Fault=0, RAS empty (RAS_Empty=1).
REQ-030 SHALL, on rst asserted mid-operation (incl. in HANDLER), discard all pending requests and resume at RESET_VECTOR on first edge after release.

Configuration
REQ-031 SHALL gate the return-address stack with macro PC_UNIT_RAS_EN.
REQ-032 SHALL, with PC_UNIT_RAS_EN defined: non-misaligned Redirect with Call pushes PC_Plus4; Ret pops top into PC; push when full overwrites oldest entry (circular, count saturates at RAS_DEPTH); Ret when empty ignored (PC advances/holds per lower priorities); Call and Ret together: Redirect/push wins, Ret ignored; Trap cancels any push/pop that cycle.
REQ-033 SHALL, with PC_UNIT_RAS_EN undefined: no RAS storage, Call and Ret ignored, RAS_Empty tied 1.

Verification
REQ-034 SHALL cover: rst=0 then release, 3 idle edges -> PC 0x000, 0x004, 0x008, 0x00C.
REQ-035 SHALL cover: PC=0x008, Redirect=1 Target=0x040 with Stall=1 -> PC=0x040 next edge; then Stall=1 alone 2 edges -> PC stays 0x040.
REQ-036 SHALL cover: PC=0x010, Redirect Target=0x022 -> PC=0x100, EPC=0x010, In_Handler=1; Trap again -> Double_Fault=1, EPC=0x010; Trap_Return -> PC=0x010, In_Handler=0.
REQ-037 SHALL cover (RAS on): Call at PC=0x004 to 0x080, Call at 0x080 to 0x0C0, Ret -> PC=0x084, Ret -> PC=0x008, Ret -> RAS_Empty=1, PC=0x00C.
REQ-038 SHALL cover (RAS on, RAS_DEPTH=4): 5 Calls then 5 Rets -> first 4 Rets return newest-first, 5th ignored.
REQ-039 SHALL cover: Redirect to 0xFFFF_FFFC, one idle edge -> PC=0x0000_0000; rst pulsed low in HANDLER -> PC=RESET_VECTOR, In_Handler=0, Double_Fault=0.
